// File: rtl/ann_input_loader.sv
// ann_input_loader
//
// Receives toggle-strobed sample words from the HPS input-data PIO and stores
// them in an on-chip frame buffer. When a frame is complete, it locks the frame
// and passes it to the ANN compute core. Software can poll status_word to pace
// its writes without using interrupts.
//
// Optional feature: define INPUT_LOADER_CHECKSUM_EN to build a 16-bit running
// checksum of the accepted samples. Without it, frame_sum is tied to 0.
//
// Ports:
//   clk          system clock (single domain)
//   reset_n      asynchronous active-low reset
//   pio_word     [19] strobe toggle, [18] last flag, [17:0] sample
//   status_word  [19] ack toggle, [18] frame_ready, [17:11] zero, [10:0] count
//   frame_ready  frame complete and locked for the core
//   frame_len    number of valid samples in the locked frame
//   frame_done   one-cycle release pulse from the core
//   rd_addr      core read address
//   rd_data      buffer[rd_addr], registered (one-cycle latency)
//   frame_sum    frame checksum (0 when the checksum is not built)
module ann_input_loader #(
  parameter int DATA_W = 18,
  parameter int DEPTH  = 784,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [19:0]       pio_word,
  output logic [19:0]       status_word,
  output logic              frame_ready,
  output logic [ADDR_W:0]   frame_len,
  input  logic              frame_done,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic [15:0]       frame_sum
);

  typedef enum logic {FILL = 1'b0, READY = 1'b1} state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W:0]   count_reg, count_next;
  logic [ADDR_W:0]   count_inc;
  logic [ADDR_W:0]   frame_len_reg, frame_len_next;
  // last_tog doubles as the ack toggle: both take pio_word[19] on every
  // accepted write and are held otherwise, so they are always equal.
  logic              last_tog_reg, last_tog_next;
  logic              strobe;
  logic              wr_en;

  logic [DATA_W-1:0] buffer [0:DEPTH-1];

  assign strobe    = (pio_word[19] != last_tog_reg);
  assign count_inc = count_reg + 1'b1;

  // State and control registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= FILL;
      count_reg     <= '0;
      frame_len_reg <= '0;
      last_tog_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      count_reg     <= count_next;
      frame_len_reg <= frame_len_next;
      last_tog_reg  <= last_tog_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next     = state_reg;
    count_next     = count_reg;
    frame_len_next = frame_len_reg;
    last_tog_next  = last_tog_reg;
    wr_en          = 1'b0;
    case (state_reg)
      FILL: begin
        // frame_done is ignored while filling.
        if (strobe) begin
          wr_en         = 1'b1;
          count_next    = count_inc;
          last_tog_next = pio_word[19];
          // A last flag and a full buffer in the same write produce one transition.
          if (pio_word[18] || (count_inc == (ADDR_W+1)'(DEPTH))) begin
            state_next     = READY;
            frame_len_next = count_inc;
          end
        end
      end
      READY: begin
        // Strobes stay pending here. A strobe that arrives together with
        // frame_done is picked up in FILL on the next cycle.
        if (frame_done) begin
          state_next = FILL;
          count_next = '0;
        end
      end
      default: state_next = FILL;
    endcase
  end

  // Frame buffer: one write port and one registered read port. The contents
  // are not reset, so the array can map onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      buffer[count_reg[ADDR_W-1:0]] <= pio_word[DATA_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_data <= '0;
    end else begin
      rd_data <= buffer[rd_addr];
    end
  end

`ifdef INPUT_LOADER_CHECKSUM_EN
  logic [15:0] frame_sum_reg;
  logic        sum_clear;

  assign sum_clear = (state_reg == READY) && frame_done;

  // No write can happen in READY, so the sum is held stable while the frame is locked.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_sum_reg <= '0;
    end else if (sum_clear) begin
      frame_sum_reg <= '0;
    end else if (wr_en) begin
      frame_sum_reg <= frame_sum_reg + pio_word[15:0];
    end
  end

  assign frame_sum = frame_sum_reg;
`else
  assign frame_sum = 16'h0000;
`endif

  assign frame_ready = (state_reg == READY);
  assign frame_len   = frame_len_reg;
  assign status_word = {last_tog_reg, frame_ready, 7'b0, 11'(count_reg)};

endmodule

// File: tb/tb_ann_input_loader.sv
module tb_ann_input_loader;

  localparam int DATA_W = 18;
  localparam int DEPTH  = 784;
  localparam int ADDR_W = 10;

  logic              clk;
  logic              reset_n;
  logic [19:0]       pio_word;
  logic [19:0]       status_word;
  logic              frame_ready;
  logic [ADDR_W:0]   frame_len;
  logic              frame_done;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [15:0]       frame_sum;

  int   n_cmp = 0;
  int   n_err = 0;
  logic tog   = 1'b0;

  ann_input_loader #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .pio_word   (pio_word),
    .status_word(status_word),
    .frame_ready(frame_ready),
    .frame_len  (frame_len),
    .frame_done (frame_done),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .frame_sum  (frame_sum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  // Called at a negedge. Toggles the strobe and returns at the next negedge,
  // after the sampling posedge.
  task automatic push(input logic [17:0] s, input logic last);
    tog      = ~tog;
    pio_word = {tog, last, s};
    @(negedge clk);
  endtask

  task automatic read_chk(input string tag, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] exp);
    rd_addr = a;
    @(negedge clk);
    check_eq(tag, 32'(rd_data), 32'(exp));
  endtask

  task automatic pulse_done;
    frame_done = 1'b1;
    @(negedge clk);
    frame_done = 1'b0;
  endtask

  function automatic logic [19:0] stat(input logic ack, input logic rdy, input int cnt);
    return {ack, rdy, 7'b0, 11'(cnt)};
  endfunction

  initial begin
    reset_n    = 1'b0;
    pio_word   = '0;
    frame_done = 1'b0;
    rd_addr    = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_status",    32'(status_word), 32'h0);
    check_eq("rst_ready",     32'(frame_ready), 32'h0);
    check_eq("rst_len",       32'(frame_len),   32'h0);
    check_eq("rst_rd_data",   32'(rd_data),     32'h0);
    check_eq("rst_frame_sum", 32'(frame_sum),   32'h0);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    check_eq("idle_status", 32'(status_word), 32'h0);
    check_eq("idle_ready",  32'(frame_ready), 32'h0);

    // Short frame: 5, -3, 100 (last)
    push(18'd5, 1'b0);
    check_eq("short_w1_status", 32'(status_word), 32'(stat(1'b1, 1'b0, 1)));
    push(18'h3FFFD, 1'b0);
    check_eq("short_w2_ready", 32'(frame_ready), 32'h0);
    push(18'd100, 1'b1);
    check_eq("short_ready",  32'(frame_ready), 32'h1);
    check_eq("short_len",    32'(frame_len),   32'd3);
    check_eq("short_status", 32'(status_word), 32'(stat(1'b1, 1'b1, 3)));
`ifdef INPUT_LOADER_CHECKSUM_EN
    check_eq("short_sum", 32'(frame_sum), 32'h0066);
`else
    check_eq("short_sum", 32'(frame_sum), 32'h0000);
`endif
    read_chk("short_rd0", 10'd0, 18'd5);
    read_chk("short_rd1", 10'd1, 18'h3FFFD);
    read_chk("short_rd2", 10'd2, 18'd100);
    pulse_done();
    check_eq("release_status", 32'(status_word), 32'(stat(1'b1, 1'b0, 0)));
    check_eq("release_sum",    32'(frame_sum),   32'h0);

    // Spurious release while filling with count=2
    push(18'd0, 1'b0);
    push(18'd1, 1'b0);
    pulse_done();
    repeat (2) @(negedge clk);
    check_eq("spurious_status", 32'(status_word), 32'(stat(1'b1, 1'b0, 2)));

    // Full buffer without a last flag
    for (int i = 2; i < DEPTH - 1; i++) push(18'(i), 1'b0);
    check_eq("full_pre_ready", 32'(frame_ready), 32'h0);
    push(18'(DEPTH - 1), 1'b0);
    check_eq("full_ready",  32'(frame_ready), 32'h1);
    check_eq("full_len",    32'(frame_len),   32'(DEPTH));
    check_eq("full_status", 32'(status_word), 32'(stat(tog, 1'b1, DEPTH)));
    read_chk("full_rd_last", 10'(DEPTH - 1), 18'(DEPTH - 1));
    read_chk("full_rd_400",  10'd400, 18'd400);

    // A 785th toggle stays pending while READY
    tog      = ~tog;
    pio_word = {tog, 1'b0, 18'h30000};
    repeat (5) @(negedge clk);
    check_eq("held_status", 32'(status_word), 32'(stat(~tog, 1'b1, DEPTH)));
    pulse_done();
    check_eq("held_rel_status", 32'(status_word), 32'(stat(~tog, 1'b0, 0)));
    @(negedge clk);
    check_eq("held_acc_status", 32'(status_word), 32'(stat(tog, 1'b0, 1)));
    read_chk("held_rd0", 10'd0, 18'h30000);

    // frame_done and a new toggle in the same READY cycle
    push(18'd7, 1'b1);
    check_eq("sim_pre_ready", 32'(frame_ready), 32'h1);
    tog        = ~tog;
    pio_word   = {tog, 1'b0, 18'h01234};
    frame_done = 1'b1;
    @(negedge clk);
    frame_done = 1'b0;
    check_eq("sim_fill_status", 32'(status_word), 32'(stat(~tog, 1'b0, 0)));
    @(negedge clk);
    check_eq("sim_acc_status", 32'(status_word), 32'(stat(tog, 1'b0, 1)));
    read_chk("sim_rd0", 10'd0, 18'h01234);

    // Reset mid-frame after 10 writes
    for (int i = 1; i < 10; i++) push(18'(i * 3), 1'b0);
    check_eq("mid_count", 32'(status_word[10:0]), 32'd10);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("mid_rst_status", 32'(status_word), 32'h0);
    check_eq("mid_rst_ready",  32'(frame_ready), 32'h0);
    check_eq("mid_rst_len",    32'(frame_len),   32'h0);
    check_eq("mid_rst_rd",     32'(rd_data),     32'h0);
    check_eq("mid_rst_sum",    32'(frame_sum),   32'h0);
    tog      = 1'b0;
    pio_word = '0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("post_rst_idle", 32'(status_word), 32'h0);
    push(18'h2AAAA, 1'b0);
    check_eq("post_rst_w1", 32'(status_word), 32'(stat(1'b1, 1'b0, 1)));
    read_chk("post_rst_rd0", 10'd0, 18'h2AAAA);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
